regfile_writer: RTL and testbench
=================================

# regfile_writer

Write side of the 32×64-bit integer register file: decodes a 5-bit destination register number, holds the 32 architectural registers in flip-flops, and presents them all as a packed `[31:0][63:0]` array. The existing 32:1 read muxes select from that array for both read ports. Register x31 is hardwired to zero, consistent with the read side.

## Interface
Parameters:
- `DW`, 64, data width of each register.
- `AW`, 5, register-number width; register count is 2**AW = 32.

Ports:
- `clk`  input  1  single clock, rising-edge.
- `reset`  input  1  asynchronous, active-high; clears every register.
- `RegWrite`  input  1  write enable for this cycle.
- `WriteRegister`  input  AW  destination register number, 0–31.
- `WriteData`  input  DW  data to write.
- `regs`  output  [2**AW-1:0][DW-1:0]  current contents of all registers; `regs[n]` is register xn.

## Operation
- Decoder: `RegWrite` and `WriteRegister` produce a one-hot 32-bit enable vector.
  - All-zero when `RegWrite`=0.
  - Bit 31 is forced to 0, so writes to x31 are discarded.
- Storage: registers x0–x30 are 64-bit flops with a per-register enable.
  - Enabled register loads `WriteData` on the rising edge of `clk`.
  - All other registers hold their value.
- x31: no storage. `regs[31]` is a constant 0 at all times, including during reset.
- At most one register changes per cycle. `regs` for all other registers is unaffected by the write.
- No read/write bypass. In the cycle a write is presented, `regs` still shows the old value; the new value appears after the edge. Same-cycle forwarding belongs to the pipeline, not this block.
- Reset:
  - `reset`=1 asynchronously drives all 32 entries of `regs` to 0.
  - Reset takes effect immediately, independent of `clk`.
  - A write presented while `reset` is high is dropped.
  - After `reset` deasserts, the first write takes effect on the first rising edge at which `reset`=0.
- `WriteData` and `WriteRegister` are don't-care when `RegWrite`=0. X on these inputs in that case must not corrupt any register.

## Timing
- Write latency: 1 cycle. Inputs are sampled at edge N; `regs[WriteRegister]` equals `WriteData` after edge N and stays stable until the next write to the same register or reset.
- `regs` is a purely registered output (except the constant x31). No combinational path exists from the inputs to `regs`.
- Back-to-back writes to the same register on consecutive cycles: each edge loads that cycle's data (last writer wins).
- Reset assertion: asynchronous. Reset deassertion: the user synchronizes it to `clk` upstream.
- Reset values: every `regs[n]` = 64'h0.

## Structure
- Package `regfile_pkg` holds:
  - `NREGS` = 32, `DW` = 64, `AW` = 5, `ZERO_REG` = 5'd31.
  - `typedef logic [NREGS-1:0][DW-1:0] reg_array_t`.
  - `regs` and the read-mux input both use `reg_array_t`.
- Sub-module `decoder5_32`: inputs `en` and `sel[4:0]`, output one-hot `out[31:0]`.
  - Built from smaller decoder stages (2:4 and 3:8), matching the structural style of the read muxes.
- The register array is generate-instantiated, 31 instances of an enabled 64-bit register. Entry 31 is tied to 0.

## Test plan
- Reset: pulse `reset` mid-cycle with no clock edge → all `regs` = 0 immediately. Then write 64'hDEAD_BEEF_0123_4567 to x5 with `reset` held high → x5 stays 0.
- Sweep all registers: for i = 0..30, write `{32'hA5A5_0000, i}` to xi, then drive the read mux with select = i → output matches. Every other register is unchanged after each write.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to x31 → `regs[31]` = 0, and the read mux with select = 31 returns 0. No other register changes.
- Write disable: set `RegWrite`=0 with `WriteRegister`=3 and `WriteData`=64'h1234, plus X data on another cycle → x3 retains its prior value.
- Back-to-back: write 1, then 2, then 3 to x7 on consecutive edges → x7 reads 1, 2, 3 after successive edges. In each write cycle, before the edge, x7 shows the previous value (confirms no bypass).
- Reset mid-stream: fill x0–x30 with nonzero values, assert `reset` between edges → all 0 at once. Deassert, write x0 = 64'h1 → only x0 = 1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizes and types for the integer register file.
// Both the write side and the read muxes use these definitions.
package regfile_pkg;
  localparam int NREGS = 32;
  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef logic [NREGS-1:0][DW-1:0] reg_array_t;
endpackage

// File: rtl/regfile_writer_decoder.sv
// 5:32 one-hot decoder for the register-file write port.
// It is built from a 2:4 stage on sel[4:3] and a 3:8 stage on sel[2:0].
module dec2to4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] out
);
  assign out = en ? (4'b0001 << sel) : 4'b0000;
endmodule

module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] out
);
  assign out = en ? (8'b0000_0001 << sel) : 8'b0000_0000;
endmodule

module decoder5_32 (
  input  logic        en,
  input  logic [4:0]  sel,
  output logic [31:0] out
);
  logic [3:0] w_hi;
  logic [7:0] w_lo;

  dec2to4 u_hi (.en(en),   .sel(sel[4:3]), .out(w_hi));
  dec3to8 u_lo (.en(1'b1), .sel(sel[2:0]), .out(w_lo));

  // The gated high group masks every bank, so en=0 yields all zeros.
  for (genvar g = 0; g < 4; g++) begin : g_bank
    assign out[g*8 +: 8] = {8{w_hi[g]}} & w_lo;
  end
endmodule

// File: rtl/regfile_writer.sv
// Write side of the 32x64 integer register file.
// x0-x30 are enabled flops, and x31 reads as a constant zero.
module regfile_writer #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       RegWrite,
  input  logic [AW-1:0]              WriteRegister,
  input  logic [DW-1:0]              WriteData,
  output logic [2**AW-1:0][DW-1:0]   regs
);
  import regfile_pkg::ZERO_REG;

  localparam int NR = 2**AW;

  logic [NR-1:0] w_dec;
  logic          w_zero_unused;

  decoder5_32 u_dec (
    .en  (RegWrite),
    .sel (WriteRegister),
    .out (w_dec)
  );

  // The decoder bit for x31 is dropped because that entry has no storage.
  assign w_zero_unused = w_dec[ZERO_REG];

  for (genvar n = 0; n < NR; n++) begin : g_reg
    if (n == int'(ZERO_REG)) begin : g_zero
      assign regs[n] = '0;
    end else begin : g_ff
      logic [DW-1:0] r_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_q <= '0;
        end else if (w_dec[n]) begin
          r_q <= WriteData;
        end
      end
      assign regs[n] = r_q;
    end
  end
endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer.
// An array model is checked against the DUT on every falling edge.
module tb_regfile_writer;
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              RegWrite = 1'b0;
  logic [4:0]        WriteRegister = '0;
  logic [63:0]       WriteData = '0;
  logic [31:0][63:0] regs;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [0:31];

  regfile_writer #(.DW(64), .AW(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .regs          (regs)
  );

  always #5 clk = ~clk;

  // Architectural model: reset clears everything, x31 never takes a write.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) model[k] = 64'h0;
    end else if (RegWrite && WriteRegister != 5'd31) begin
      model[WriteRegister] = WriteData;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 32; k++)
      chk($sformatf("%s regs[%0d]", tag, k), regs[k], model[k]);
  endtask

  function automatic logic [63:0] rmux(input logic [4:0] sel);
    return regs[sel];
  endfunction

  always @(negedge clk) check_all("cycle");

  task automatic wr(input logic we, input logic [4:0] r, input logic [63:0] d);
    RegWrite = we;
    WriteRegister = r;
    WriteData = d;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) model[k] = 64'h0;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check_all("reset");

    // A write made while reset is held high is dropped.
    wr(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567);
    chk("x5 write during reset", regs[5], 64'h0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Load every register, then clear them with a reset pulse between edges.
    for (int i = 0; i < 31; i++) wr(1'b1, 5'(i), 64'hFFFF_0000_0000_0000 | 64'(i + 1));
    chk("x9 prefill", regs[9], 64'hFFFF_0000_0000_000A);
    #1 reset = 1'b1;
    #1 check_all("async reset");
    chk("x9 after async reset", regs[9], 64'h0);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 31; i++) begin
      wr(1'b1, 5'(i), {32'hA5A5_0000, 32'(i)});
      chk($sformatf("mux sel=%0d", i), rmux(5'(i)), {32'hA5A5_0000, 32'(i)});
    end
    chk("x30 literal", regs[30], 64'hA5A5_0000_0000_001E);

    wr(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("x31 after write", regs[31], 64'h0);
    chk("mux sel=31", rmux(5'd31), 64'h0);
    chk("x30 untouched", regs[30], 64'hA5A5_0000_0000_001E);

    wr(1'b0, 5'd3, 64'h1234);
    chk("x3 write disabled", regs[3], 64'hA5A5_0000_0000_0003);
    wr(1'b0, 5'd3, 64'hx);
    chk("x3 X data disabled", regs[3], 64'hA5A5_0000_0000_0003);

    // Consecutive writes to x7; before each edge the old value must still show.
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'd1;
    #1 chk("x7 no bypass 1", regs[7], 64'hA5A5_0000_0000_0007);
    @(posedge clk); #1;
    chk("x7 after 1", regs[7], 64'd1);
    WriteData = 64'd2;
    #1 chk("x7 no bypass 2", regs[7], 64'd1);
    @(posedge clk); #1;
    chk("x7 after 2", regs[7], 64'd2);
    WriteData = 64'd3;
    #1 chk("x7 no bypass 3", regs[7], 64'd2);
    @(posedge clk); #1;
    chk("x7 after 3", regs[7], 64'd3);
    RegWrite = 1'b0;

    #1 reset = 1'b1;
    #1 check_all("reset midstream");
    #1 reset = 1'b0;
    wr(1'b1, 5'd0, 64'h1);
    chk("x0 after reset", regs[0], 64'h1);
    chk("x1 after reset", regs[1], 64'h0);
    chk("x7 after reset", regs[7], 64'h0);

    @(posedge clk); #1;
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
